sound_rom_slave: RTL and testbench



---
 rtl/sound_rom_slave.sv | 118 +++++++++++
 tb/tb_sound_rom_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sound_rom_slave.sv
// rtl/sound_rom_slave.sv - Avalon-MM read-only burst responder over a packed-sample ROM
// Optional multi-beat bursts: define SOUND_ROM_BURST_EN; otherwise every request is one beat.
module sound_rom_slave #(
  parameter int    ADDR_W    = 17,
  parameter int    DATA_W    = 32,
  parameter int    BURST_W   = 4,
  parameter int    MEM_DEPTH = 95671,
  parameter string INIT_FILE = "sound.mif"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  avmm_data_addr,
  input  logic               avmm_data_read,
  input  logic [BURST_W-1:0] avmm_data_burstcount,
  output logic               avmm_data_waitrequest,
  output logic [DATA_W-1:0]  avmm_data_readdata,
  output logic               avmm_data_readdatavalid,
  output logic               range_err
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state_q, state_d;
  logic                accept;
  logic                lookup_en;
  logic                last_beat;
  logic                in_range;
  logic [ADDR_W-1:0]   beat_addr_q;
  logic [DATA_W-1:0]   readdata_q;
  logic                readdatavalid_q;
  logic                range_err_q;

  // Contents come from the MIF at device configuration; there is no write port.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] rom_q [0:MEM_DEPTH-1];

  assign accept   = (state_q == S_IDLE) && avmm_data_read;
  assign in_range = {1'b0, beat_addr_q} < (ADDR_W+1)'(MEM_DEPTH);

`ifdef SOUND_ROM_BURST_EN
  logic [BURST_W-1:0] remaining_q;

  assign last_beat = remaining_q <= BURST_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
    end else if (accept) begin
      remaining_q <= (avmm_data_burstcount == '0) ? BURST_W'(1) : avmm_data_burstcount;
    end else if (lookup_en) begin
      remaining_q <= remaining_q - BURST_W'(1);
    end
  end
`else
  logic unused_burstcount;

  assign last_beat         = 1'b1;
  assign unused_burstcount = ^avmm_data_burstcount;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (avmm_data_read) state_d = S_BURST;
      S_BURST: if (last_beat)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avmm_data_waitrequest = 1'b0;
    lookup_en             = 1'b0;
    if (state_q == S_BURST) begin
      avmm_data_waitrequest = 1'b1;
      lookup_en             = 1'b1;
    end
  end

  // Beat address advances modulo 2^ADDR_W, so a burst near the top wraps to word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_addr_q <= '0;
    end else if (accept) begin
      beat_addr_q <= avmm_data_addr;
    end else if (lookup_en) begin
      beat_addr_q <= beat_addr_q + ADDR_W'(1);
    end
  end

  // The ROM output register doubles as readdata, giving a two-cycle first-data latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      range_err_q     <= 1'b0;
    end else begin
      readdatavalid_q <= lookup_en;
      if (lookup_en) begin
        readdata_q <= in_range ? rom_q[beat_addr_q] : '0;
        if (!in_range) begin
          range_err_q <= 1'b1;
        end
      end
    end
  end

  assign avmm_data_readdata      = readdata_q;
  assign avmm_data_readdatavalid = readdatavalid_q;
  assign range_err               = range_err_q;

endmodule

// File: tb/tb_sound_rom_slave.sv
// tb/tb_sound_rom_slave.sv - scoreboard bench for sound_rom_slave with word[a] = a*3
// Honours SOUND_ROM_BURST_EN in its reference model the same way the design does.
module tb_sound_rom_slave;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BURST_W = 4;
  localparam int DEPTH = 95671;
  localparam int ASPACE = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [BURST_W-1:0] bc = '0;
  logic wr, rv, rerr;
  logic [DATA_W-1:0] rdata;

  sound_rom_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MEM_DEPTH(DEPTH), .INIT_FILE("sound.mif")
  ) dut (
    .clk(clk), .reset(reset),
    .avmm_data_addr(addr), .avmm_data_read(rd), .avmm_data_burstcount(bc),
    .avmm_data_waitrequest(wr), .avmm_data_readdata(rdata),
    .avmm_data_readdatavalid(rv), .range_err(rerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          err;
  } beat_t;

  beat_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_end = -1;
  bit armed = 1'b0;
  bit err_sched = 1'b0;
  bit err_now = 1'b0;
  logic [31:0] last_data = '0;
  bit exp_wait, exp_v;
  beat_t e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(int a);
    return (a < DEPTH) ? 32'(a * 3) : 32'd0;
  endfunction

  function automatic int beats_of(int b);
`ifdef SOUND_ROM_BURST_EN
    return (b == 0) ? 1 : b;
`else
    return 1;
`endif
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Monitor: compare this cycle's outputs, then fold this cycle's inputs into the model.
  always @(negedge clk) begin
    if (armed) begin
      exp_wait = (cyc <= busy_end);
      chk("waitrequest", {31'd0, wr}, {31'd0, exp_wait});
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("readdatavalid", {31'd0, rv}, {31'd0, exp_v});
      if (exp_v) begin
        e = exp_q.pop_front();
        last_data = e.data;
        err_now = e.err;
        if (rv) chk("readdata", rdata, e.data);
      end else begin
        chk("readdata_hold", rdata, last_data);
      end
      chk("range_err", {31'd0, rerr}, {31'd0, err_now});
    end
    if (reset) begin
      exp_q.delete();
      busy_end = cyc;
      err_sched = 1'b0;
      err_now = 1'b0;
      last_data = '0;
      armed = 1'b1;
    end else if (armed && rd && !(cyc <= busy_end)) begin
      int n, a;
      n = beats_of(int'(bc));
      busy_end = cyc + n;
      for (int k = 0; k < n; k++) begin
        a = (int'(addr) + k) % ASPACE;
        if (a >= DEPTH) err_sched = 1'b1;
        exp_q.push_back('{due: cyc + 2 + k, data: word_at(a), err: err_sched});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until accepted; returns one cycle after acceptance.
  task automatic do_req(input int a, input int b);
    bit acc;
    acc = 1'b0;
    rd = 1'b1;
    addr = ADDR_W'(a);
    bc = BURST_W'(b);
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = !wr;
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout addr %0d: got no acceptance, expected one within 64 cycles", a);
    end
  endtask

  task automatic stall_pulse();
    rd = 1'b1;
    addr = ADDR_W'($urandom_range(0, ASPACE - 1));
    bc = BURST_W'($urandom_range(0, 15));
    idle(1);
    rd = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    int sel, a;
    for (int i = 0; i < DEPTH; i++) dut.rom_q[i] = 32'(i * 3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    do_req(100, 1);
    idle(4);
    do_req(35729, 4);
    do_req(0, 2);
    idle(5);
    do_req(100, 1);
    stall_pulse();
    idle(4);
    do_req(95670, 3);
    idle(5);
    do_req(ASPACE - 1, 2);
    idle(4);
    do_req(200, 8);
    idle(2);
    reset_pulse();
    idle(1);
    do_req(10, 5);
    idle(8);

    for (int it = 0; it < 80; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: a = int'($urandom_range(0, DEPTH - 1));
        1: a = int'($urandom_range(DEPTH - 8, DEPTH + 3));
        2: a = int'($urandom_range(ASPACE - 6, ASPACE - 1));
        default: a = int'($urandom_range(0, ASPACE - 1));
      endcase
      idle(int'($urandom_range(0, 2)));
      do_req(a, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) stall_pulse();
      if ($urandom_range(0, 9) == 0) begin
        idle(int'($urandom_range(0, 3)));
        reset_pulse();
      end
    end

    idle(25);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
